// File: rtl/cond_result_buffer.sv
// Result buffer behind the conditional select y = (c != 0) ? a : b.
// First-word-fall-through FIFO with per-path saturating counters and a sticky drop flag.
module cond_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic                   out_sel,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       a_cnt,
  output logic [CNT_W-1:0]       b_cnt,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]   b_cnt_q, b_cnt_d;
  logic               overflow_q, overflow_d;
  logic               push, pop;
  logic [WIDTH:0]     head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is gated by empty so uninitialised storage never reaches the outputs
  assign head      = mem_q[rd_ptr_q];
  assign out_y     = empty ? '0 : head[WIDTH-1:0];
  assign out_sel   = empty ? 1'b0 : head[WIDTH];
  assign count     = count_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (in_sel) a_cnt_d = sat_inc(a_cnt_q);
      else        b_cnt_d = sat_inc(b_cnt_q);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_sel, in_y};
  end

endmodule

// File: tb/tb_cond_result_buffer.sv
// Bench for cond_result_buffer: directed vector table, then randomized traffic against a queue model.
module tb_cond_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_sel, out_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_ready, out_valid, out_sel, full, empty, overflow;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       count;
  logic [7:0]       a_cnt, b_cnt;
  logic             s_in_ready, s_out_valid, s_out_sel, s_full, s_empty, s_overflow;
  logic [WIDTH-1:0] s_out_y;
  logic [2:0]       s_count;
  logic [1:0]       s_a_cnt, s_b_cnt;

  cond_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_sel(out_sel), .count(count), .full(full), .empty(empty), .a_cnt(a_cnt),
    .b_cnt(b_cnt), .overflow(overflow));

  // Same traffic into a 2-bit-counter instance to exercise saturation
  cond_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_y(in_y),
    .in_sel(in_sel), .out_valid(s_out_valid), .out_ready(out_ready), .out_y(s_out_y),
    .out_sel(s_out_sel), .count(s_count), .full(s_full), .empty(s_empty), .a_cnt(s_a_cnt),
    .b_cnt(s_b_cnt), .overflow(s_overflow));

  typedef struct {
    bit rst; bit iv; bit [3:0] y; bit sel; bit ordy;
    int ec; bit [3:0] ey; bit es; int ea; int eb; int esa; int esb; bit eo;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  logic [4:0] mq[$];
  int ma, mb, msa, msb;
  bit mo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_step(input bit r, input bit iv, input bit [3:0] y, input bit sel,
                            input bit ordy);
    bit do_push, do_pop;
    if (r) begin
      mq.delete();
      ma = 0; mb = 0; msa = 0; msb = 0; mo = 0;
    end else begin
      do_push = iv && (mq.size() < DEPTH);
      do_pop  = ordy && (mq.size() > 0);
      if (iv && mq.size() == DEPTH) mo = 1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({sel, y});
        if (sel) begin ma = sat(ma, 255); msa = sat(msa, 3); end
        else     begin mb = sat(mb, 255); msb = sat(msb, 3); end
      end
    end
  endtask

  task automatic check_model();
    int n;
    logic [4:0] h;
    n = mq.size();
    h = (n > 0) ? mq[0] : 5'd0;
    chk("m_count", 32'(count), 32'(n));
    chk("m_full", 32'(full), 32'(n == DEPTH));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("m_out_valid", 32'(out_valid), 32'(n != 0));
    chk("m_out_y", 32'(out_y), 32'(h[3:0]));
    chk("m_out_sel", 32'(out_sel), 32'(h[4]));
    chk("m_a_cnt", 32'(a_cnt), 32'(ma));
    chk("m_b_cnt", 32'(b_cnt), 32'(mb));
    chk("m_overflow", 32'(overflow), 32'(mo));
    chk("m_sat_a", 32'(s_a_cnt), 32'(msa));
    chk("m_sat_b", 32'(s_b_cnt), 32'(msb));
    chk("m_sat_out_y", 32'(s_out_y), 32'(h[3:0]));
  endtask

  task automatic apply(input bit r, input bit iv, input bit [3:0] y, input bit sel,
                       input bit ordy);
    rst = r; in_valid = iv; in_y = y; in_sel = sel; out_ready = ordy;
    @(posedge clk);
    model_step(r, iv, y, sel, ordy);
    #1;
  endtask

  function automatic vec_t v(input bit r, input bit iv, input bit [3:0] y, input bit sel,
                             input bit ordy, input int ec, input bit [3:0] ey, input bit es,
                             input int ea, input int eb, input int esa, input int esb,
                             input bit eo);
    vec_t t;
    t.rst = r; t.iv = iv; t.y = y; t.sel = sel; t.ordy = ordy;
    t.ec = ec; t.ey = ey; t.es = es; t.ea = ea; t.eb = eb; t.esa = esa; t.esb = esb; t.eo = eo;
    return t;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_sel = 1'b0; out_ready = 1'b0;
    ma = 0; mb = 0; msa = 0; msb = 0; mo = 0;

    //          rst iv y     sel or   cnt y     s  a  b  sa sb ovf
    tbl.push_back(v(1, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(v(1, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0)); // idle
    tbl.push_back(v(0, 1, 4'hE, 1, 0,  1, 4'hE, 1, 1, 0, 1, 0, 0)); // a-path result
    tbl.push_back(v(0, 1, 4'h5, 0, 0,  2, 4'hE, 1, 1, 1, 1, 1, 0)); // b-path result
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  1, 4'h5, 0, 1, 1, 1, 1, 0)); // drain
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  0, 4'h0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, 1, 4'h1, 0, 0,  1, 4'h1, 0, 1, 2, 1, 2, 0)); // fill
    tbl.push_back(v(0, 1, 4'h2, 1, 0,  2, 4'h1, 0, 2, 2, 2, 2, 0));
    tbl.push_back(v(0, 1, 4'h3, 0, 0,  3, 4'h1, 0, 2, 3, 2, 3, 0));
    tbl.push_back(v(0, 1, 4'h4, 1, 0,  4, 4'h1, 0, 3, 3, 3, 3, 0));
    tbl.push_back(v(0, 1, 4'h5, 1, 0,  4, 4'h1, 0, 3, 3, 3, 3, 1)); // dropped offer
    tbl.push_back(v(0, 0, 4'h0, 0, 0,  4, 4'h1, 0, 3, 3, 3, 3, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  3, 4'h2, 1, 3, 3, 3, 3, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  2, 4'h3, 0, 3, 3, 3, 3, 1));
    tbl.push_back(v(0, 1, 4'h7, 0, 1,  2, 4'h4, 1, 3, 4, 3, 3, 1)); // push+pop
    tbl.push_back(v(0, 1, 4'h8, 1, 1,  2, 4'h7, 0, 4, 4, 3, 3, 1));
    tbl.push_back(v(0, 1, 4'h9, 0, 1,  2, 4'h8, 1, 4, 5, 3, 3, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  1, 4'h9, 0, 4, 5, 3, 3, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  0, 4'h0, 0, 4, 5, 3, 3, 1));
    tbl.push_back(v(0, 1, 4'h1, 1, 0,  1, 4'h1, 1, 5, 5, 3, 3, 1)); // build count=3
    tbl.push_back(v(0, 1, 4'h2, 1, 0,  2, 4'h1, 1, 6, 5, 3, 3, 1));
    tbl.push_back(v(0, 1, 4'h3, 1, 0,  3, 4'h1, 1, 7, 5, 3, 3, 1));
    tbl.push_back(v(1, 1, 4'hF, 1, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0)); // mid-op reset
    tbl.push_back(v(0, 1, 4'hA, 0, 0,  1, 4'hA, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  0, 4'h0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(1, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0)); // saturation run
    tbl.push_back(v(0, 1, 4'h1, 1, 1,  1, 4'h1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 4'h2, 1, 1,  1, 4'h2, 1, 2, 0, 2, 0, 0));
    tbl.push_back(v(0, 1, 4'h3, 1, 1,  1, 4'h3, 1, 3, 0, 3, 0, 0));
    tbl.push_back(v(0, 1, 4'h4, 1, 1,  1, 4'h4, 1, 4, 0, 3, 0, 0));
    tbl.push_back(v(0, 1, 4'h5, 1, 1,  1, 4'h5, 1, 5, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 4'h0, 0, 1,  0, 4'h0, 0, 5, 0, 3, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step = i;
      apply(tbl[i].rst, tbl[i].iv, tbl[i].y, tbl[i].sel, tbl[i].ordy);
      chk("count", 32'(count), 32'(tbl[i].ec));
      chk("full", 32'(full), 32'(tbl[i].ec == DEPTH));
      chk("empty", 32'(empty), 32'(tbl[i].ec == 0));
      chk("in_ready", 32'(in_ready), 32'(tbl[i].ec != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(tbl[i].ec != 0));
      chk("out_y", 32'(out_y), 32'(tbl[i].ey));
      chk("out_sel", 32'(out_sel), 32'(tbl[i].es));
      chk("a_cnt", 32'(a_cnt), 32'(tbl[i].ea));
      chk("b_cnt", 32'(b_cnt), 32'(tbl[i].eb));
      chk("sat_a_cnt", 32'(s_a_cnt), 32'(tbl[i].esa));
      chk("sat_b_cnt", 32'(s_b_cnt), 32'(tbl[i].esb));
      chk("overflow", 32'(overflow), 32'(tbl[i].eo));
      chk("sat_overflow", 32'(s_overflow), 32'(tbl[i].eo));
      check_model();
    end

    for (int i = 0; i < 600; i++) begin
      step = 1000 + i;
      apply(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0);
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
